// File: rtl/nn_pkg.sv
// Shared definitions for the NN SRAM path: bus widths and the arbiter state encoding.
package nn_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WEIGHT_W    = 32;
  localparam int unsigned NN_ADDR_W   = SRAM_ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NN_LO    = 3'd1,
    NN_HI    = 3'd2,
    NN_ACK   = 3'd3,
    WR_SETUP = 3'd4,
    WR_PULSE = 3'd5,
    WR_ACK   = 3'd6
  } sram_arb_state_t;

endpackage

// File: rtl/nn_sram_arbiter.sv
// Arbitrates the external async SRAM between the NN weight reader (two 16-bit halves -> 32-bit)
// and the loader writer, with a starvation guard and programmable strobe width.
module nn_sram_arbiter
  import nn_pkg::*;
#(
  parameter int unsigned ACCESS_CYC   = 2,
  parameter int unsigned MAX_NN_BURST = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   nn_req,
  input  logic [NN_ADDR_W-1:0]   nn_addr,
  output logic [WEIGHT_W-1:0]    nn_rdata,
  output logic                   nn_ack,
  input  logic                   wr_req,
  input  logic [SRAM_ADDR_W-1:0] wr_addr,
  input  logic [SRAM_DATA_W-1:0] wr_data,
  output logic                   wr_ack,
  output logic                   CE_N,
  output logic                   OE_N,
  output logic                   WE_N,
  output logic                   UB_N,
  output logic                   LB_N,
  output logic [SRAM_ADDR_W-1:0] ADDR,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  input  logic [SRAM_DATA_W-1:0] sram_rdata,
  output logic                   data_oe
);

  localparam int unsigned CNT_W   = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_NN_BURST + 1);

  sram_arb_state_t        r_state;
  sram_arb_state_t        w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [BURST_W-1:0]     r_burst_cnt;
  logic [NN_ADDR_W-1:0]   r_nn_addr;
  logic [SRAM_ADDR_W-1:0] r_wr_addr;
  logic [SRAM_DATA_W-1:0] r_wr_data;
  logic [SRAM_DATA_W-1:0] r_lo;

  logic                   w_last;
  logic                   w_grant_nn;
  logic                   w_grant_wr;
  logic [NN_ADDR_W-1:0]   w_nn_addr_sel;
  logic [SRAM_ADDR_W-1:0] w_wr_addr_sel;
  logic [SRAM_DATA_W-1:0] w_wr_data_sel;

  logic                   w_ce_n;
  logic                   w_oe_n;
  logic                   w_we_n;
  logic [SRAM_ADDR_W-1:0] w_addr;
  logic [SRAM_DATA_W-1:0] w_wdata;
  logic                   w_data_oe;
  logic                   w_nn_ack;
  logic                   w_wr_ack;
  logic [WEIGHT_W-1:0]    w_nn_rdata;

  assign w_last = (r_cnt == CNT_W'(ACCESS_CYC - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and arbitration; the writer wins a tie only once the NN burst limit is reached
  always_comb begin
    w_next_state = r_state;
    w_grant_nn   = 1'b0;
    w_grant_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (nn_req && !(wr_req && (r_burst_cnt == BURST_W'(MAX_NN_BURST)))) begin
          w_grant_nn   = 1'b1;
          w_next_state = NN_LO;
        end else if (wr_req) begin
          w_grant_wr   = 1'b1;
          w_next_state = WR_SETUP;
        end
      end
      NN_LO:    if (w_last) w_next_state = NN_HI;
      NN_HI:    if (w_last) w_next_state = NN_ACK;
      NN_ACK:   w_next_state = IDLE;
      WR_SETUP: w_next_state = WR_PULSE;
      WR_PULSE: if (w_last) w_next_state = WR_ACK;
      WR_ACK:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Output decode from the next state so every pin is registered and aligned with its state
  always_comb begin
    w_ce_n        = 1'b1;
    w_oe_n        = 1'b1;
    w_we_n        = 1'b1;
    w_addr        = '0;
    w_wdata       = '0;
    w_data_oe     = 1'b0;
    w_nn_ack      = 1'b0;
    w_wr_ack      = 1'b0;
    w_nn_rdata    = nn_rdata;
    w_nn_addr_sel = w_grant_nn ? nn_addr : r_nn_addr;
    w_wr_addr_sel = w_grant_wr ? wr_addr : r_wr_addr;
    w_wr_data_sel = w_grant_wr ? wr_data : r_wr_data;
    case (w_next_state)
      NN_LO: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_addr = {w_nn_addr_sel, 1'b0};
      end
      NN_HI: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_addr = {r_nn_addr, 1'b1};
      end
      NN_ACK: begin
        w_ce_n     = 1'b0;
        w_addr     = {r_nn_addr, 1'b1};
        w_nn_ack   = 1'b1;
        w_nn_rdata = {sram_rdata, r_lo};
      end
      WR_SETUP, WR_PULSE, WR_ACK: begin
        w_ce_n    = 1'b0;
        w_we_n    = (w_next_state != WR_PULSE);
        w_addr    = w_wr_addr_sel;
        w_wdata   = w_wr_data_sel;
        w_data_oe = 1'b1;
        w_wr_ack  = (w_next_state == WR_ACK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt       <= '0;
      r_burst_cnt <= '0;
      r_nn_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_lo        <= '0;
      CE_N        <= 1'b1;
      OE_N        <= 1'b1;
      WE_N        <= 1'b1;
      UB_N        <= 1'b1;
      LB_N        <= 1'b1;
      ADDR        <= '0;
      sram_wdata  <= '0;
      data_oe     <= 1'b0;
      nn_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      nn_rdata    <= '0;
    end else begin
      r_cnt <= (w_next_state == r_state) ? r_cnt + CNT_W'(1) : '0;
      if (w_grant_wr)      r_burst_cnt <= '0;
      else if (w_grant_nn) r_burst_cnt <= wr_req ? r_burst_cnt + BURST_W'(1) : '0;
      if (w_grant_nn) r_nn_addr <= nn_addr;
      if (w_grant_wr) begin
        r_wr_addr <= wr_addr;
        r_wr_data <= wr_data;
      end
      if ((r_state == NN_LO) && w_last) r_lo <= sram_rdata;
      CE_N       <= w_ce_n;
      OE_N       <= w_oe_n;
      WE_N       <= w_we_n;
      UB_N       <= w_ce_n;
      LB_N       <= w_ce_n;
      ADDR       <= w_addr;
      sram_wdata <= w_wdata;
      data_oe    <= w_data_oe;
      nn_ack     <= w_nn_ack;
      wr_ack     <= w_wr_ack;
      nn_rdata   <= w_nn_rdata;
    end
  end

endmodule

// File: tb/tb_nn_sram_arbiter.sv
// Scoreboard bench for nn_sram_arbiter: directed timing checks, contention, reset abort,
// randomized traffic against a transaction-level model, and an ACCESS_CYC sweep.
module tb_nn_sram_arbiter;
  import nn_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        nn_req, nn_ack, wr_req, wr_ack;
  logic [18:0] nn_addr;
  logic [31:0] nn_rdata;
  logic [19:0] wr_addr, addr;
  logic [15:0] wr_data, sram_wdata, sram_rdata;
  logic        ce_n, oe_n, we_n, ub_n, lb_n, data_oe;

  logic [15:0] mem [0:(1<<20)-1];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rd [$];
  logic [35:0] exp_wr [$];

  // Background SRAM contents: an address hash the bench can recompute independently
  function automatic logic [15:0] f(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], a[11:0]} ^ 16'h3C5A;
  endfunction

  assign sram_rdata = (!ce_n && !oe_n) ? mem[addr] : 16'hDEAD;
  always @(posedge clk) if (ce_n === 1'b0 && we_n === 1'b0) mem[addr] = sram_wdata;

  nn_sram_arbiter u_dut (
    .Clk(clk), .Rst_n(rst_n),
    .nn_req(nn_req), .nn_addr(nn_addr), .nn_rdata(nn_rdata), .nn_ack(nn_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n), .UB_N(ub_n), .LB_N(lb_n),
    .ADDR(addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .data_oe(data_oe)
  );

  // Sweep instances: [0] ACCESS_CYC=1, [1] ACCESS_CYC=4
  logic        s_nn_req [2];
  logic [18:0] s_nn_addr [2];
  logic [31:0] s_nn_rdata [2];
  logic        s_nn_ack [2];
  logic        s_wr_req [2];
  logic [19:0] s_wr_addr [2];
  logic [15:0] s_wr_data [2];
  logic        s_wr_ack [2];
  logic        s_ce [2], s_oe [2], s_we [2], s_ub [2], s_lb [2], s_doe [2];
  logic [19:0] s_addr [2];
  logic [15:0] s_wdata [2], s_rdata [2];

  assign s_rdata[0] = (!s_ce[0] && !s_oe[0]) ? f(s_addr[0]) : 16'hDEAD;
  assign s_rdata[1] = (!s_ce[1] && !s_oe[1]) ? f(s_addr[1]) : 16'hDEAD;

  nn_sram_arbiter #(.ACCESS_CYC(1)) u_a1 (
    .Clk(clk), .Rst_n(rst_n),
    .nn_req(s_nn_req[0]), .nn_addr(s_nn_addr[0]), .nn_rdata(s_nn_rdata[0]), .nn_ack(s_nn_ack[0]),
    .wr_req(s_wr_req[0]), .wr_addr(s_wr_addr[0]), .wr_data(s_wr_data[0]), .wr_ack(s_wr_ack[0]),
    .CE_N(s_ce[0]), .OE_N(s_oe[0]), .WE_N(s_we[0]), .UB_N(s_ub[0]), .LB_N(s_lb[0]),
    .ADDR(s_addr[0]), .sram_wdata(s_wdata[0]), .sram_rdata(s_rdata[0]), .data_oe(s_doe[0])
  );

  nn_sram_arbiter #(.ACCESS_CYC(4)) u_a4 (
    .Clk(clk), .Rst_n(rst_n),
    .nn_req(s_nn_req[1]), .nn_addr(s_nn_addr[1]), .nn_rdata(s_nn_rdata[1]), .nn_ack(s_nn_ack[1]),
    .wr_req(s_wr_req[1]), .wr_addr(s_wr_addr[1]), .wr_data(s_wr_data[1]), .wr_ack(s_wr_ack[1]),
    .CE_N(s_ce[1]), .OE_N(s_oe[1]), .WE_N(s_we[1]), .UB_N(s_ub[1]), .LB_N(s_lb[1]),
    .ADDR(s_addr[1]), .sram_wdata(s_wdata[1]), .sram_rdata(s_rdata[1]), .data_oe(s_doe[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pops the expected response whenever the DUT acks
  always @(negedge clk) begin
    logic [31:0] er;
    logic [35:0] ew;
    if (nn_ack === 1'b1) begin
      if (exp_rd.size() == 0) chk("nn_ack_unexpected", 64'(1), 64'(0));
      else begin
        er = exp_rd.pop_front();
        chk("nn_rdata", 64'(nn_rdata), 64'(er));
      end
    end
    if (wr_ack === 1'b1) begin
      if (exp_wr.size() == 0) chk("wr_ack_unexpected", 64'(1), 64'(0));
      else begin
        ew = exp_wr.pop_front();
        chk("wr_addr_at_ack", 64'(addr), 64'(ew[35:16]));
        chk("wr_mem", 64'(mem[ew[35:16]]), 64'(ew[15:0]));
      end
    end
    if (ce_n === 1'b0)
      chk("strobe_excl", 64'(!oe_n && (!we_n || data_oe)), 64'(0));
  end

  task automatic run_txn(input bit is_wr, output int lat, output logic [15:0] smask,
                         output logic [15:0] bmask);
    lat = -1; smask = '0; bmask = '0;
    if (is_wr) wr_req = 1'b1; else nn_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c < 16) begin
        smask[c] = is_wr ? (we_n === 1'b0) : (oe_n === 1'b0);
        bmask[c] = (addr === wr_addr) && (sram_wdata === wr_data) && (data_oe === 1'b1);
      end
      if ((is_wr ? wr_ack : nn_ack) === 1'b1) begin
        lat = c;
        break;
      end
    end
    nn_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic nn_driver();
    for (int t = 0; t < 40; t++) begin
      logic [18:0] a;
      int gap;
      bit ok;
      a   = {2'b01, 17'($urandom)};
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        nn_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      nn_addr = a;
      exp_rd.push_back({f({a, 1'b1}), f({a, 1'b0})});
      nn_req = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (nn_ack === 1'b1) begin
          ok = 1'b1;
          break;
        end
        if (c == 2 && $urandom_range(0, 7) == 0 && oe_n === 1'b0) nn_req = 1'b0;
      end
      if (!ok) chk("nn_rand_timeout", 64'(0), 64'(1));
    end
    nn_req = 1'b0;
  endtask

  task automatic wr_driver();
    for (int t = 0; t < 30; t++) begin
      int gap;
      bit ok;
      gap = $urandom_range(0, 4);
      if (gap > 0) begin
        wr_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      wr_addr = {1'b1, 19'($urandom)};
      wr_data = 16'($urandom);
      exp_wr.push_back({wr_addr, wr_data});
      wr_req = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (wr_ack === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("wr_rand_timeout", 64'(0), 64'(1));
    end
    wr_req = 1'b0;
  endtask

  int          lat;
  logic [15:0] m1, m2;

  initial begin
    logic [18:0] ca;
    logic [31:0] ce;
    logic [17:0] seq;
    int          n_acks;
    int          cnt;
    bit          found;

    rst_n = 1'b0; nn_req = 1'b0; wr_req = 1'b0;
    nn_addr = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      s_nn_req[i] = 1'b0; s_wr_req[i] = 1'b0;
      s_nn_addr[i] = '0; s_wr_addr[i] = '0; s_wr_data[i] = '0;
    end
    for (int i = 0; i < (1 << 20); i++) mem[i] = f(20'(i));
    mem[20'h00020] = 16'hBEEF;
    mem[20'h00021] = 16'h1234;

    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({ce_n, oe_n, we_n, ub_n, lb_n}), 64'(5'h1F));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_data_oe", 64'(data_oe), 64'(0));
    chk("rst_acks", 64'({nn_ack, wr_ack}), 64'(0));
    chk("rst_nn_rdata", 64'(nn_rdata), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed NN read
    nn_addr = 19'h00010;
    exp_rd.push_back(32'h1234BEEF);
    run_txn(1'b0, lat, m1, m2);
    chk("nn_latency", 64'(lat), 64'(5));
    chk("nn_oe_window", 64'(m1), 64'(16'h001E));
    repeat (2) @(negedge clk);

    // Directed write
    wr_addr = 20'h0ABCD;
    wr_data = 16'h5A5A;
    exp_wr.push_back({wr_addr, wr_data});
    run_txn(1'b1, lat, m1, m2);
    chk("wr_latency", 64'(lat), 64'(4));
    chk("wr_we_window", 64'(m1), 64'(16'h000C));
    chk("wr_bus_window", 64'(m2), 64'(16'h001E));
    chk("nn_rdata_hold", 64'(nn_rdata), 64'(32'h1234BEEF));
    @(negedge clk);
    chk("wr_mem_5a5a", 64'(mem[20'h0ABCD]), 64'(16'h5A5A));
    repeat (2) @(negedge clk);

    // Contention: both requests held high
    ca = 19'h21234;
    ce = {f({ca, 1'b1}), f({ca, 1'b0})};
    nn_addr = ca;
    wr_addr = 20'h81111;
    wr_data = 16'hC0DE;
    exp_rd.push_back(ce);
    exp_wr.push_back({wr_addr, wr_data});
    nn_req = 1'b1; wr_req = 1'b1;
    seq = '0; n_acks = 0;
    for (int c = 0; c < 400 && n_acks < 18; c++) begin
      @(negedge clk);
      if (nn_ack === 1'b1) begin
        n_acks++;
        if (n_acks < 18) exp_rd.push_back(ce);
      end
      if (wr_ack === 1'b1) begin
        seq[n_acks] = 1'b1;
        n_acks++;
        if (n_acks < 18) exp_wr.push_back({wr_addr, wr_data});
      end
    end
    nn_req = 1'b0; wr_req = 1'b0;
    chk("contention_count", 64'(n_acks), 64'(18));
    chk("contention_order", 64'(seq), 64'(18'h20100));
    repeat (3) @(negedge clk);
    exp_rd.delete();
    exp_wr.delete();

    // Reset in the middle of a write pulse
    wr_addr = 20'h04444;
    wr_data = 16'h1111;
    wr_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (we_n === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_pulse_seen", 64'(found), 64'(1));
    rst_n = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 64'(we_n), 64'(1));
    chk("abort_idle_strobes", 64'({ce_n, oe_n, ub_n, lb_n}), 64'(4'hF));
    chk("abort_bus", 64'({addr, data_oe, wr_ack}), 64'(0));
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) cnt++;
    end
    chk("abort_no_wr_ack", 64'(cnt), 64'(0));
    wr_addr = 20'h05555;
    wr_data = 16'h2222;
    exp_wr.push_back({wr_addr, wr_data});
    run_txn(1'b1, lat, m1, m2);
    chk("post_abort_wr_latency", 64'(lat), 64'(4));
    repeat (2) @(negedge clk);

    // Randomized concurrent traffic
    fork
      nn_driver();
      wr_driver();
    join
    repeat (6) @(negedge clk);
    chk("sb_rd_drained", 64'(exp_rd.size()), 64'(0));
    chk("sb_wr_drained", 64'(exp_wr.size()), 64'(0));

    // ACCESS_CYC sweep
    for (int i = 0; i < 2; i++) begin
      int a;
      logic [31:0] got;
      a = (i == 0) ? 1 : 4;
      s_nn_addr[i] = 19'h20ABC;
      s_nn_req[i] = 1'b1;
      lat = -1; got = '0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (s_nn_ack[i] === 1'b1) begin
          lat = c;
          got = s_nn_rdata[i];
          break;
        end
      end
      s_nn_req[i] = 1'b0;
      chk("sweep_nn_latency", 64'(lat), 64'(2 * a + 1));
      chk("sweep_nn_rdata", 64'(got), 64'({f(20'h41579), f(20'h41578)}));
      repeat (2) @(negedge clk);
      s_wr_addr[i] = 20'h0C0C0;
      s_wr_data[i] = 16'h7E57;
      s_wr_req[i] = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (s_wr_ack[i] === 1'b1) begin
          lat = c;
          chk("sweep_wr_bus", 64'({s_addr[i], s_wdata[i], s_doe[i]}), 64'({20'h0C0C0, 16'h7E57, 1'b1}));
          chk("sweep_wr_strobes", 64'({s_ce[i], s_ub[i], s_lb[i], s_we[i]}), 64'(4'b0001));
          break;
        end
      end
      s_wr_req[i] = 1'b0;
      chk("sweep_wr_latency", 64'(lat), 64'(a + 2));
      repeat (2) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_sram_arbiter.md
# nn_sram_arbiter

Shares the single external 16-bit asynchronous SRAM between the neural-network weight fetcher (`nn`, read-only, 32-bit weights) and the image/weight loader (write-only, 16-bit words). Runs a fixed-priority arbiter with a starvation guard, sequences SRAM control strobes with programmable access time, and assembles two 16-bit reads into one 32-bit weight. It sits between `nn`/loader and the top-level SRAM pins. Tri-state buffering stays at top level.

## Interface
Parameters:
- `ACCESS_CYC`, default 2: cycles each SRAM read or write strobe is held (≥1).
- `MAX_NN_BURST`, default 8: consecutive NN grants allowed while a write is pending before the writer is forced in (≥1).

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Rst_n` in 1: reset, synchronous and active-low.
- `nn_req` in 1: NN weight read request, level, held until `nn_ack`.
- `nn_addr` in 19: weight index; SRAM words `{nn_addr,0}` (low half) and `{nn_addr,1}` (high half).
- `nn_rdata` out 32: assembled weight `{hi,lo}`, valid while `nn_ack` is high and held afterward.
- `nn_ack` out 1: one-cycle completion pulse.
- `wr_req` in 1: loader write request, level, held until `wr_ack`.
- `wr_addr` in 20 / `wr_data` in 16: write word address and data.
- `wr_ack` out 1: one-cycle completion pulse.
- `CE_N`, `OE_N`, `WE_N`, `UB_N`, `LB_N` out 1 each: SRAM strobes, active-low.
- `ADDR` out 20: SRAM address.
- `sram_wdata` out 16: write data to pad.
- `sram_rdata` in 16: read data from pad.
- `data_oe` out 1: high means the top level drives `sram_wdata` onto the pad.

## Operation
- FSM states: `IDLE`, `NN_LO`, `NN_HI`, `NN_ACK`, `WR_SETUP`, `WR_PULSE`, `WR_ACK`.
- Arbitration in `IDLE`:
  - One request only: grant it.
  - Both requests: grant NN unless `burst_cnt == MAX_NN_BURST`, in which case grant the writer.
  - `burst_cnt` increments on each NN grant made while `wr_req=1`.
  - `burst_cnt` clears on a writer grant, and on an NN grant made while `wr_req=0`.
- NN read sequence:
  - `NN_LO`: ACCESS_CYC cycles, `ADDR={nn_addr,0}`, `OE_N=0`. Sample `sram_rdata` into lo at the last cycle.
  - `NN_HI`: same, with `ADDR={nn_addr,1}`, into hi.
  - `NN_ACK`: `nn_rdata={hi,lo}`, `nn_ack=1`, return to `IDLE`.
  - `nn_addr` is latched at grant.
- Write sequence:
  - `WR_SETUP`: 1 cycle, address and data driven, `data_oe=1`, `WE_N=1`.
  - `WR_PULSE`: ACCESS_CYC cycles with `WE_N=0`.
  - `WR_ACK`: 1 cycle, `WE_N=1`, address, data and `data_oe` held for hold time, `wr_ack=1`.
  - `wr_addr` and `wr_data` are latched at grant.
- Strobe rules:
  - `CE_N=UB_N=LB_N=0` in every non-`IDLE` state, 1 in `IDLE`.
  - `OE_N=0` only in `NN_LO`/`NN_HI`.
  - `OE_N` and `WE_N` are never both 0.
  - `data_oe=1` only in write states.
- A request still high in the cycle after its ack is a new transaction and is arbitrated again.
- Request dropped mid-transaction: the transaction completes and the ack still pulses.
- `Rst_n=0` at any edge, including mid-write:
  - Next state is `IDLE`, `burst_cnt=0`.
  - All strobes go to 1, `ADDR=0`, `data_oe=0`, both acks 0, `nn_rdata=0`.
  - No ack is issued for the aborted transaction.

## Timing
- All outputs are registered and change only on the `Clk` rising edge.
- Grant happens on the edge where `IDLE` sees a request; strobes assert in the following cycle.
- NN latency, request sampled to `nn_ack` high: 2·ACCESS_CYC+1 cycles (5 at default). Bus occupancy is 2·ACCESS_CYC+1 cycles.
- Write latency, request sampled to `wr_ack` high: ACCESS_CYC+2 cycles (4 at default).
- `IDLE` lasts at least 1 cycle between transactions. Back-to-back NN reads therefore issue every 2·ACCESS_CYC+2 cycles.
- Worst-case writer wait: MAX_NN_BURST NN transactions.

## Structure
- Shared package `nn_pkg`:
  - `SRAM_ADDR_W=20`, `SRAM_DATA_W=16`, `WEIGHT_W=32`.
  - Enum `sram_arb_state_t` for the FSM states.
- Single module with no sub-module. The access-cycle counter and `burst_cnt` are local registers.
- `nn` connects `nn_req`/`nn_addr`/`nn_rdata`/`nn_ack` in place of its direct SRAM port.

## Test plan
- Reset: after hold, `CE_N=OE_N=WE_N=1`, `ADDR=0`, `data_oe=0`, acks 0.
- NN read: `nn_addr=0x00010`, SRAM model returns 0xBEEF at 0x00020 and 0x1234 at 0x00021. Required: `nn_ack` at cycle 5 with `nn_rdata=0x1234BEEF`, and `OE_N=0` only during cycles 1–4.
- Write: `wr_addr=0x0ABCD`, `wr_data=0x5A5A`. Required: `WE_N=0` for exactly 2 cycles, address and data stable one cycle before and one cycle after the pulse, `wr_ack` at cycle 4, and the model holds 0x5A5A.
- Contention: `nn_req` and `wr_req` held high continuously. Required: exactly 8 `nn_ack` pulses, then 1 `wr_ack`, then the pattern repeats, with no overlapping strobes.
- Mid-write reset: assert `Rst_n=0` during `WR_PULSE`. Required: `WE_N=1` on the next edge, no `wr_ack`, FSM in `IDLE`. A fresh request after reset completes normally.
- Sweep `ACCESS_CYC=1` and `ACCESS_CYC=4`. Required: NN latency 3 and 9 cycles, write latency 3 and 6 cycles.
